// File: rtl/disp_ctl_pkg.sv
// Shared types and width helpers for the HUB75 display controller.
package disp_ctl_pkg;

  typedef enum logic [2:0] {
    StLoad,
    StShift,
    StLatch,
    StGuard,
    StDisplay
  } state_e;

  // Columns per row.
  function automatic int unsigned row_elem(input int unsigned col_addr_bits);
    return 32'd1 << col_addr_bits;
  endfunction

  // Bits of one colour channel across a whole row.
  function automatic int unsigned color_dat_width(input int unsigned col_addr_bits,
                                                  input int unsigned color_bits);
    return row_elem(col_addr_bits) * color_bits;
  endfunction

  // Bits of a whole row, all colour channels.
  function automatic int unsigned row_dat_width(input int unsigned col_addr_bits,
                                                input int unsigned color_bits,
                                                input int unsigned color_count);
    return color_dat_width(col_addr_bits, color_bits) * color_count;
  endfunction

endpackage

// File: rtl/disp_ctl_pixel_mux.sv
// Selects bit[plane] of pixel(column) for every colour channel of the row shadow.
module disp_ctl_pixel_mux
  import disp_ctl_pkg::*;
#(
  parameter int unsigned COLOR_BITS    = 4,
  parameter int unsigned COL_ADDR_BITS = 6,
  parameter int unsigned COLOR_COUNT   = 3,
  parameter int unsigned PLANE_BITS    = 2
) (
  input  logic [row_dat_width(COL_ADDR_BITS, COLOR_BITS, COLOR_COUNT)-1:0] shadow,
  input  logic [COL_ADDR_BITS-1:0]                                         column,
  input  logic [PLANE_BITS-1:0]                                            plane,
  output logic [COLOR_COUNT-1:0]                                           bits
);

  localparam int unsigned RowElem = row_elem(COL_ADDR_BITS);

  // Packed view matching the row layout: colour, then column, then plane bit.
  logic [COLOR_COUNT-1:0][RowElem-1:0][COLOR_BITS-1:0] pix;

  assign pix = shadow;

  // One bit per colour from the addressed pixel and plane.
  always_comb begin
    bits = '0;
    for (int c = 0; c < COLOR_COUNT; c++) begin
      bits[c] = pix[c][column][plane];
    end
  end

endmodule

// File: rtl/display_control.sv
// HUB75 matrix driver: loads a row, shifts each bit-plane out, latches it and
// lights it for a binary-weighted time. Define DISP_CTL_NOE_GUARD_EN to add a
// 2-cycle blanked settle state between latch and display.
module display_control
  import disp_ctl_pkg::*;
#(
  parameter int unsigned COLOR_BITS     = 4,
  parameter int unsigned COL_ADDR_BITS  = 6,
  parameter int unsigned ROW_ADDR_BITS  = 4,
  parameter int unsigned COLOR_COUNT    = 3,
  parameter int unsigned BASE_ON_CYCLES = 8
) (
  input  logic                                                             clk,
  input  logic                                                             rst,
  input  logic [row_dat_width(COL_ADDR_BITS, COLOR_BITS, COLOR_COUNT)-1:0] row_in,
  output logic [ROW_ADDR_BITS-1:0]                                         next_row,
  output logic                                                             hub_clk,
  output logic                                                             hub_noe,
  output logic                                                             hub_lat,
  output logic [ROW_ADDR_BITS-1:0]                                         hub_mux,
  output logic [COLOR_COUNT-1:0]                                           s_out
);

  localparam int unsigned RowDatWidth = row_dat_width(COL_ADDR_BITS, COLOR_BITS, COLOR_COUNT);
  localparam int unsigned PlaneW      = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int unsigned CntW        = $clog2(BASE_ON_CYCLES << COLOR_BITS);

  state_e                   state;
  logic [RowDatWidth-1:0]   shadow;
  logic [ROW_ADDR_BITS-1:0] row;
  logic [PlaneW-1:0]        plane;
  logic [COL_ADDR_BITS-1:0] column;
  logic                     phase;
  logic [CntW-1:0]          cnt;
  logic [COLOR_COUNT-1:0]   plane_bits;

  disp_ctl_pixel_mux #(
    .COLOR_BITS   (COLOR_BITS),
    .COL_ADDR_BITS(COL_ADDR_BITS),
    .COLOR_COUNT  (COLOR_COUNT),
    .PLANE_BITS   (PlaneW)
  ) u_pixel_mux (
    .shadow(shadow),
    .column(column),
    .plane (plane),
    .bits  (plane_bits)
  );

  // Display time of the current plane, minus one for the down-counter.
  function automatic logic [CntW-1:0] on_count(input logic [PlaneW-1:0] p);
    return CntW'((BASE_ON_CYCLES << p) - 1);
  endfunction

  // Row/plane sequencer with all panel outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StLoad;
      shadow   <= '0;
      row      <= '0;
      plane    <= '0;
      column   <= '0;
      phase    <= 1'b0;
      cnt      <= '0;
      next_row <= '0;
      hub_clk  <= 1'b0;
      hub_noe  <= 1'b1;
      hub_lat  <= 1'b0;
      hub_mux  <= '0;
      s_out    <= '0;
    end else begin
      unique case (state)
        StLoad: begin
          shadow   <= row_in;
          next_row <= row + 1'b1;
          plane    <= '0;
          column   <= '1;
          phase    <= 1'b0;
          hub_clk  <= 1'b0;
          hub_lat  <= 1'b0;
          hub_noe  <= 1'b1;
          state    <= StShift;
        end
        StShift: begin
          hub_lat <= 1'b0;
          hub_noe <= 1'b1;
          if (!phase) begin
            s_out   <= plane_bits;
            hub_clk <= 1'b0;
            phase   <= 1'b1;
          end else begin
            hub_clk <= 1'b1;
            phase   <= 1'b0;
            if (column == '0) begin
              state <= StLatch;
            end else begin
              column <= column - 1'b1;
            end
          end
        end
        StLatch: begin
          hub_clk <= 1'b0;
          hub_lat <= 1'b1;
          hub_mux <= row;
          hub_noe <= 1'b1;
`ifdef DISP_CTL_NOE_GUARD_EN
          cnt     <= CntW'(1);
          state   <= StGuard;
`else
          cnt     <= on_count(plane);
          state   <= StDisplay;
`endif
        end
        StGuard: begin
          // Keep the panel blanked while the row drivers settle on the new mux value.
          hub_lat <= 1'b0;
          hub_noe <= 1'b1;
          if (cnt == '0) begin
            cnt   <= on_count(plane);
            state <= StDisplay;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StDisplay: begin
          hub_lat <= 1'b0;
          hub_noe <= 1'b0;
          if (cnt == '0) begin
            if (plane == PlaneW'(COLOR_BITS - 1)) begin
              row   <= row + 1'b1;
              state <= StLoad;
            end else begin
              plane  <= plane + 1'b1;
              column <= '1;
              phase  <= 1'b0;
              state  <= StShift;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_display_control.sv
// Self-checking bench for display_control: a cycle-timeline reference model
// derived from the row schedule, plus direct waveform measurements.
module tb_display_control;

  localparam int CB   = 4;
  localparam int CAB  = 6;
  localparam int RAB  = 4;
  localparam int CC   = 3;
  localparam int BASE = 8;
  localparam int RE   = 1 << CAB;
  localparam int CDW  = RE * CB;
  localparam int RDW  = CDW * CC;
  localparam int NROW = 1 << RAB;
`ifdef DISP_CTL_NOE_GUARD_EN
  localparam int G = 2;
`else
  localparam int G = 0;
`endif
  localparam int P = 1 + CB * (2 * RE + 1 + G) + BASE * ((1 << CB) - 1);
  localparam int MaxErr = 40;
  localparam logic [14:0] RstVec = {4'd0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0};

  logic           clk;
  logic           rst;
  logic [RDW-1:0] row_in;
  logic [RAB-1:0] next_row;
  logic           hub_clk;
  logic           hub_noe;
  logic           hub_lat;
  logic [RAB-1:0] hub_mux;
  logic [CC-1:0]  s_out;

  logic [RDW-1:0] frame [NROW];
  logic [RDW-1:0] snap;
  logic [CC-1:0]  exp_s;
  logic [3:0]     pat;
  int             checks;
  int             errors;
  int             e;
  bit             directed;
  logic           pclk, plat, pnoe;
  int             clk_rises, noe_len, rows_seen, lat_in_row, nr_e;
  logic [RAB-1:0] nr_prev;

  assign row_in = frame[next_row];

  display_control dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .next_row(next_row),
    .hub_clk (hub_clk),
    .hub_noe (hub_noe),
    .hub_lat (hub_lat),
    .hub_mux (hub_mux),
    .s_out   (s_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  function automatic logic [14:0] got_vec();
    return {next_row, hub_mux, s_out, hub_noe, hub_lat, hub_clk};
  endfunction

  function automatic logic [RDW-1:0] rand_row();
    logic [RDW-1:0] v;
    for (int k = 0; k < RDW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Expected outputs after edge e, from the row schedule: LOAD edge, then per plane
  // 2*RE shift edges, one latch edge, G guard edges and BASE<<p display edges.
  task automatic model_after_edge(output logic [14:0] ev);
    int o, r, p, j, rem;
    logic [RAB-1:0] nr, mux;
    logic ck, lt, ne;
    o = (e - 1) % P;
    r = (e - 1) / P;
    p = 0;
    j = 0;
    if (o > 0) begin
      rem = o - 1;
      while (rem >= 2 * RE + 1 + G + (BASE << p)) begin
        rem -= 2 * RE + 1 + G + (BASE << p);
        p++;
      end
      j = rem;
    end
    nr  = RAB'((r + 1) % NROW);
    if (o > 0 && (p > 0 || j >= 2 * RE)) mux = RAB'(r % NROW);
    else mux = (r > 0) ? RAB'((r - 1) % NROW) : '0;
    ck = (o > 0) && (j < 2 * RE) && (j % 2 == 1);
    lt = (o > 0) && (j == 2 * RE);
    ne = !((o > 0) && (j >= 2 * RE + 1 + G));
    if (o > 0 && j < 2 * RE && j % 2 == 0) begin
      for (int c = 0; c < CC; c++) exp_s[c] = snap[c*CDW + (RE - 1 - j / 2) * CB + p];
    end
    ev = {nr, mux, exp_s, ne, lt, ck};
  endtask

  // Independent waveform measurements: edge counts, on-times, sequencing, periods.
  task automatic measure();
    if (!hub_noe) noe_len++;
    if (hub_noe && !pnoe) begin
      check_eq("on_time", noe_len, BASE << (lat_in_row - 1));
      noe_len = 0;
    end
    if (next_row != nr_prev) begin
      rows_seen++;
      check_eq("next_row", next_row, rows_seen % NROW);
      if (nr_e >= 0) check_eq("row_period", e - nr_e, P);
      nr_e       = e;
      lat_in_row = 0;
      nr_prev    = next_row;
    end
    if (hub_clk && !pclk) begin
      clk_rises++;
      if (directed && rows_seen == 1 && clk_rises == 1)
        check_eq("pixel", s_out, {2'b00, pat[lat_in_row]});
    end
    if (hub_lat && !plat) begin
      check_eq("clk_edges", clk_rises, RE);
      clk_rises = 0;
      if (lat_in_row == 0) begin
        check_eq("mux_row", hub_mux, (rows_seen - 1) % NROW);
        check_eq("lat_delay", e - nr_e, 2 * RE + 1);
      end
      lat_in_row++;
    end
    pclk = hub_clk;
    plat = hub_lat;
    pnoe = hub_noe;
  endtask

  task automatic reset_model();
    e          = 0;
    exp_s      = '0;
    pclk       = 1'b0;
    plat       = 1'b0;
    pnoe       = 1'b1;
    clk_rises  = 0;
    noe_len    = 0;
    rows_seen  = 0;
    lat_in_row = 0;
    nr_e       = -1;
    nr_prev    = '0;
    snap       = frame[0];
  endtask

  task automatic run(input int n);
    logic [14:0] ev;
    for (int i = 0; i < n && errors < MaxErr; i++) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      model_after_edge(ev);
      check_eq("outputs", got_vec(), ev);
      measure();
      // Row data may change at any time; only the LOAD-edge value matters.
      if (!directed && $urandom_range(0, 7) == 0)
        frame[$urandom_range(0, NROW - 1)] = rand_row();
      if (e % P == 0) snap = frame[(e / P) % NROW];
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    directed = 1'b1;
    pat      = 4'hA;
    rst      = 1'b1;
    for (int r = 0; r < NROW; r++) frame[r] = '0;
    frame[0][(RE - 1) * CB +: CB] = pat;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset", got_vec(), RstVec);
    rst = 1'b0;

    // Single lit pixel in row 0, then partway into row 1's shift.
    run(P + 40);
    for (int k = 0; k < 2 && !hub_clk; k++) run(1);
    check_eq("pre_reset_clk", hub_clk, 1'b1);
    #2 rst = 1'b1;
    #1 check_eq("async_reset", got_vec(), RstVec);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Random frame content with random rewrites, 17 rows to cover the wrap.
    directed = 1'b0;
    for (int r = 0; r < NROW; r++) frame[r] = rand_row();
    reset_model();
    rst = 1'b0;
    run(17 * P + 5);
    check_eq("rows_seen", rows_seen, errors < MaxErr ? 18 : rows_seen);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
